// File: rtl/sync_fifo_if.sv
// Handshake bundle between a synchronous FIFO and its user.
// The master side pushes and pops; the slave side is the FIFO itself.
`timescale 1ns/1ps
interface sync_fifo_if #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8
);
  logic                wpush;
  logic [DATASIZE-1:0] wdata;
  logic                rpop;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                afull;
  logic                aempty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output wpush, wdata, rpop,
    input  rdata, rvalid, wfull, rempty, afull, aempty, count, overflow, underflow
  );

  modport slave (
    input  wpush, wdata, rpop,
    output rdata, rvalid, wfull, rempty, afull, aempty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/almost flags, occupancy and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; standard registered reads otherwise.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int ADDRSIZE  = 4,
  parameter int DATASIZE  = 8,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input logic       clk,
  input logic       rst,
  sync_fifo_if.slave fifo
);
  localparam int DEPTH = 2**ADDRSIZE;

  typedef logic [ADDRSIZE:0]   ptr_t;
  typedef logic [ADDRSIZE-1:0] addr_t;

  localparam ptr_t AFULL_V  = ptr_t'(AFULL_TH);
  localparam ptr_t AEMPTY_V = ptr_t'(AEMPTY_TH);
  localparam ptr_t FULL_XOR = ptr_t'(DEPTH);

  logic [DATASIZE-1:0] r_mem [DEPTH];
  ptr_t                r_wptr;
  ptr_t                r_rptr;
  ptr_t                r_count;
  logic                r_wfull;
  logic                r_rempty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_overflow;
  logic                r_underflow;
  logic [DATASIZE-1:0] r_rdata;
  logic                r_rvalid;

  logic                w_push_ok;
  logic                w_pop_ok;
  ptr_t                w_wptr_nxt;
  ptr_t                w_rptr_nxt;
  ptr_t                w_count_nxt;
  logic                w_rempty_nxt;
  logic                w_wfull_nxt;
  addr_t               w_waddr;
  addr_t               w_raddr;
  addr_t               w_raddr_nxt;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_push_ok    = fifo.wpush & ~r_wfull;
    w_pop_ok     = fifo.rpop & ~r_rempty;
    w_wptr_nxt   = r_wptr + ptr_t'(w_push_ok);
    w_rptr_nxt   = r_rptr + ptr_t'(w_pop_ok);
    w_count_nxt  = w_wptr_nxt - w_rptr_nxt;
    w_rempty_nxt = (w_wptr_nxt == w_rptr_nxt);
    w_wfull_nxt  = ((w_wptr_nxt ^ w_rptr_nxt) == FULL_XOR);
    w_waddr      = r_wptr[ADDRSIZE-1:0];
    w_raddr      = r_rptr[ADDRSIZE-1:0];
    w_raddr_nxt  = w_rptr_nxt[ADDRSIZE-1:0];
  end

  // NOTE: storage has no reset on purpose; only pointers and flags define validity, so clearing RAM is wasted logic.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[w_waddr] <= fifo.wdata;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_wfull     <= 1'b0;
      r_rempty    <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_wfull  <= w_wfull_nxt;
      r_rempty <= w_rempty_nxt;
      r_afull  <= (w_count_nxt >= AFULL_V);
      r_aempty <= (w_count_nxt <= AEMPTY_V);
      if (fifo.wpush && r_wfull) r_overflow  <= 1'b1;
      if (fifo.rpop && r_rempty) r_underflow <= 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      // The next head may be the word being written this very edge, so forward it.
      if (!w_rempty_nxt) begin
        if (w_push_ok && (w_waddr == w_raddr_nxt)) r_rdata <= fifo.wdata;
        else                                       r_rdata <= r_mem[w_raddr_nxt];
      end
      r_rvalid <= ~w_rempty_nxt;
`else
      if (w_pop_ok) r_rdata <= r_mem[w_raddr];
      r_rvalid <= w_pop_ok;
`endif
    end
  end

`ifndef SYNC_FIFO_FWFT_EN
  logic w_unused;
  assign w_unused = ^w_raddr_nxt;
`endif

  assign fifo.rdata     = r_rdata;
  assign fifo.rvalid    = r_rvalid;
  assign fifo.wfull     = r_wfull;
  assign fifo.rempty    = r_rempty;
  assign fifo.afull     = r_afull;
  assign fifo.aempty    = r_aempty;
  assign fifo.count     = r_count;
  assign fifo.overflow  = r_overflow;
  assign fifo.underflow = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default 16x8, AFULL_TH=14, AEMPTY_TH=2).
// Read expectations follow SYNC_FIFO_FWFT_EN the same way the design does.
`timescale 1ns/1ps
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] q [$];

  sync_fifo_if #(.ADDRSIZE(4), .DATASIZE(8)) fifo_if ();

  sync_fifo #(.ADDRSIZE(4), .DATASIZE(8), .AFULL_TH(14), .AEMPTY_TH(2)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (fifo_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_if.wpush = 1'b1;
    fifo_if.wdata = d;
    tick();
    fifo_if.wpush = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    check({tag, "_rdata"}, 32'(fifo_if.rdata), 32'(exp));
    check({tag, "_rvalid"}, 32'(fifo_if.rvalid), 32'd1);
    fifo_if.rpop = 1'b1;
    tick();
    fifo_if.rpop = 1'b0;
`else
    fifo_if.rpop = 1'b1;
    tick();
    fifo_if.rpop = 1'b0;
    check({tag, "_rdata"}, 32'(fifo_if.rdata), 32'(exp));
    check({tag, "_rvalid"}, 32'(fifo_if.rvalid), 32'd1);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_if.wpush = 1'b0;
    fifo_if.wdata = '0;
    fifo_if.rpop  = 1'b0;
    do_reset();

    // Reset state
    check("rst_count", 32'(fifo_if.count), 32'd0);
    check("rst_rempty", 32'(fifo_if.rempty), 32'd1);
    check("rst_aempty", 32'(fifo_if.aempty), 32'd1);
    check("rst_wfull", 32'(fifo_if.wfull), 32'd0);
    check("rst_afull", 32'(fifo_if.afull), 32'd0);
    check("rst_rdata", 32'(fifo_if.rdata), 32'd0);
    check("rst_rvalid", 32'(fifo_if.rvalid), 32'd0);
    check("rst_ovf", 32'(fifo_if.overflow), 32'd0);
    check("rst_unf", 32'(fifo_if.underflow), 32'd0);

    // Three pushes, then drain in order
    push(8'h11);
    check("p1_count", 32'(fifo_if.count), 32'd1);
    check("p1_rempty", 32'(fifo_if.rempty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    check("p1_fwft_rdata", 32'(fifo_if.rdata), 32'h11);
    check("p1_fwft_rvalid", 32'(fifo_if.rvalid), 32'd1);
`else
    check("p1_rvalid", 32'(fifo_if.rvalid), 32'd0);
`endif
    push(8'h22);
    check("p2_aempty", 32'(fifo_if.aempty), 32'd1);
    push(8'h33);
    check("p3_count", 32'(fifo_if.count), 32'd3);
    check("p3_rempty", 32'(fifo_if.rempty), 32'd0);
    check("p3_aempty", 32'(fifo_if.aempty), 32'd0);
    pop_check("d1", 8'h11);
    pop_check("d2", 8'h22);
    pop_check("d3", 8'h33);
    tick();
    check("d_count", 32'(fifo_if.count), 32'd0);
    check("d_rempty", 32'(fifo_if.rempty), 32'd1);
    check("d_rvalid", 32'(fifo_if.rvalid), 32'd0);

    // Underflow: rejected pop, sticky flag, data held
    fifo_if.rpop = 1'b1;
    tick();
    fifo_if.rpop = 1'b0;
    check("unf_flag", 32'(fifo_if.underflow), 32'd1);
    check("unf_rvalid", 32'(fifo_if.rvalid), 32'd0);
    check("unf_rdata", 32'(fifo_if.rdata), 32'h33);
    check("unf_count", 32'(fifo_if.count), 32'd0);
    push(8'h5A);
    pop_check("unf_after", 8'h5A);
    tick();
    check("unf_sticky", 32'(fifo_if.underflow), 32'd1);
    check("unf_ovf", 32'(fifo_if.overflow), 32'd0);
    do_reset();
    check("unf_cleared", 32'(fifo_if.underflow), 32'd0);

    // Fill to full, watching almost-full and full
    for (int k = 1; k <= 16; k++) begin
      push(8'(8'h40 + k - 1));
      check($sformatf("fill%0d_count", k), 32'(fifo_if.count), 32'(k));
      check($sformatf("fill%0d_afull", k), 32'(fifo_if.afull), 32'(k >= 14));
      check($sformatf("fill%0d_wfull", k), 32'(fifo_if.wfull), 32'(k == 16));
      check($sformatf("fill%0d_aempty", k), 32'(fifo_if.aempty), 32'(k <= 2));
    end
    // Push on full with a simultaneous pop: pop wins, push rejected
    fifo_if.wpush = 1'b1;
    fifo_if.wdata = 8'h99;
    fifo_if.rpop  = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    check("ovf_head", 32'(fifo_if.rdata), 32'h40);
`endif
    tick();
    fifo_if.wpush = 1'b0;
    fifo_if.rpop  = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    check("ovf_rdata", 32'(fifo_if.rdata), 32'h40);
`endif
    check("ovf_count", 32'(fifo_if.count), 32'd15);
    check("ovf_flag", 32'(fifo_if.overflow), 32'd1);
    check("ovf_wfull", 32'(fifo_if.wfull), 32'd0);
    check("ovf_afull", 32'(fifo_if.afull), 32'd1);
    for (int j = 0; j < 15; j++) pop_check($sformatf("ovf_d%0d", j), 8'(8'h41 + j));
    check("ovf_empty", 32'(fifo_if.rempty), 32'd1);
    check("ovf_sticky", 32'(fifo_if.overflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(fifo_if.overflow), 32'd0);

    // Steady push+pop at count 5; pointers wrap past 31
    for (int j = 0; j < 5; j++) begin
      push(8'(8'h60 + j));
      q.push_back(8'(8'h60 + j));
    end
    for (int i = 0; i < 40; i++) begin
      fifo_if.wpush = 1'b1;
      fifo_if.wdata = 8'(8'h65 + i);
      fifo_if.rpop  = 1'b1;
      q.push_back(8'(8'h65 + i));
`ifdef SYNC_FIFO_FWFT_EN
      check($sformatf("ss%0d_rdata", i), 32'(fifo_if.rdata), 32'(q.pop_front()));
      tick();
`else
      tick();
      check($sformatf("ss%0d_rdata", i), 32'(fifo_if.rdata), 32'(q.pop_front()));
`endif
      check($sformatf("ss%0d_count", i), 32'(fifo_if.count), 32'd5);
    end
    fifo_if.wpush = 1'b0;
    fifo_if.rpop  = 1'b0;
    for (int j = 0; j < 5; j++) pop_check($sformatf("ss_d%0d", j), q.pop_front());
    check("ss_empty", 32'(fifo_if.rempty), 32'd1);

    // Single word into an empty FIFO
    push(8'hA5);
`ifdef SYNC_FIFO_FWFT_EN
    check("a5_rdata", 32'(fifo_if.rdata), 32'hA5);
    check("a5_rvalid", 32'(fifo_if.rvalid), 32'd1);
    fifo_if.rpop = 1'b1;
    tick();
    fifo_if.rpop = 1'b0;
    check("a5_gone", 32'(fifo_if.rvalid), 32'd0);
    check("a5_hold", 32'(fifo_if.rdata), 32'hA5);
`else
    check("a5_pre_rvalid", 32'(fifo_if.rvalid), 32'd0);
    pop_check("a5", 8'hA5);
    tick();
    check("a5_pulse_end", 32'(fifo_if.rvalid), 32'd0);
    check("a5_hold", 32'(fifo_if.rdata), 32'hA5);
`endif

    // Reset mid-traffic with both error flags set
    fifo_if.rpop = 1'b1;
    tick();
    fifo_if.rpop = 1'b0;
    for (int j = 0; j < 7; j++) push(8'(8'hC0 + j));
    for (int j = 0; j < 10; j++) push(8'hEE);
    check("mr_pre_count", 32'(fifo_if.count), 32'd16);
    check("mr_pre_ovf", 32'(fifo_if.overflow), 32'd1);
    check("mr_pre_unf", 32'(fifo_if.underflow), 32'd1);
    fifo_if.rpop = 1'b1;
    repeat (9) tick();
    check("mr_seven", 32'(fifo_if.count), 32'd7);
    fifo_if.wpush = 1'b1;
    fifo_if.wdata = 8'h77;
    rst = 1'b1;
    tick();
    check("mr_count", 32'(fifo_if.count), 32'd0);
    check("mr_rempty", 32'(fifo_if.rempty), 32'd1);
    check("mr_ovf", 32'(fifo_if.overflow), 32'd0);
    check("mr_unf", 32'(fifo_if.underflow), 32'd0);
    check("mr_rvalid", 32'(fifo_if.rvalid), 32'd0);
    fifo_if.wpush = 1'b0;
    fifo_if.rpop  = 1'b0;
    rst = 1'b0;
    tick();
    check("mr_after_count", 32'(fifo_if.count), 32'd0);
    check("mr_after_wfull", 32'(fifo_if.wfull), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
